gate_sensor_fsm: RTL and testbench

Gate front-end for the car garage. It takes two raw beam-break sensors at the single garage gate: A on the street side, B on the garage side. It synchronizes and debounces them, then tracks the order in which a vehicle breaks and clears the beams. It issues one-cycle `car_enter` / `car_out` pulses that drive the garage up/down counter and the garage controller directly. Aborted passages, glitches and stuck sensors produce no count pulse.

---
 rtl/gate_sensor_fsm_if.sv | 29 ++
 rtl/gate_sensor_fsm.sv | 186 ++++++++++++++++++
 tb/tb_gate_sensor_fsm.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_sensor_fsm_if.sv
// Signal bundle between the gate beam sensors / garage controller and the
// gate front-end. The master side drives the raw sensors and garage_full;
// the slave side is the front-end that produces the event pulses.
interface gate_sensor_fsm_if;
    // Transfer rules: there is no valid/ready pair. Each output is a
    // registered strobe that is high for exactly one clk cycle per event.
    // There is no backpressure, so the consumer must sample every cycle.
    // sensor_a/sensor_b are raw levels (1 = beam blocked) and may change at
    // any time. garage_full is a level that is synchronous to clk.
    logic       sensor_a;
    logic       sensor_b;
    logic       garage_full;
    logic       car_enter;
    logic       car_out;
    logic       full_alarm;
    logic       sensor_fault;
    // Debug view of the passage tracker; value 0 always means IDLE.
    logic [2:0] fsm_state;

    modport master (
        output sensor_a, sensor_b, garage_full,
        input  car_enter, car_out, full_alarm, sensor_fault, fsm_state
    );

    modport slave (
        input  sensor_a, sensor_b, garage_full,
        output car_enter, car_out, full_alarm, sensor_fault, fsm_state
    );
endinterface

// File: rtl/gate_sensor_fsm.sv
// Gate front-end: synchronizes and debounces the two beam sensors, then
// follows the order in which a vehicle breaks and clears the beams. It emits
// one-cycle entry and exit pulses. A per-state timeout turns a stuck passage
// into a sensor_fault pulse and parks the tracker until both beams clear.
module gate_sensor_fsm #(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 1000,
    parameter int TW       = 16
) (
    input  logic               clk,
    input  logic               reset,
    gate_sensor_fsm_if.slave   bus
);

    // Debounce counter only needs to hold 0..DEBOUNCE-1.
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IN_A     = 3'd1,
        IN_AB    = 3'd2,
        IN_B     = 3'd3,
        OUT_B    = 3'd4,
        OUT_BA   = 3'd5,
        OUT_A    = 3'd6,
        WAIT_CLR = 3'd7
    } state_t;

    // Bit 1 carries sensor A, bit 0 carries sensor B throughout.
    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    logic [1:0]          deb_q, deb_d;
    logic [1:0][DW-1:0]  db_cnt_q, db_cnt_d;

    state_t              state_q, state_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic                enter_q, enter_d;
    logic                out_q, out_d;
    logic                alarm_q, alarm_d;
    logic                fault_q, fault_d;

    logic                a, b;
    logic                tracking;

    assign sync1_d = {bus.sensor_a, bus.sensor_b};
    assign sync2_d = sync1_q;
    assign a       = deb_q[1];
    assign b       = deb_q[0];

    // Accept a sensor change only after DEBOUNCE consecutive differing samples.
    always_comb begin
        db_cnt_d = db_cnt_q;
        deb_d    = deb_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i]    = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    // Synchronizer and debouncer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign tracking = (state_q != IDLE) && (state_q != WAIT_CLR);

    // Passage tracking, event pulses and per-state timeout.
    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        out_d   = 1'b0;
        alarm_d = 1'b0;
        fault_d = 1'b0;
        tmr_d   = '0;

        case (state_q)
            IDLE: begin
                if (a && !b) begin
                    state_d = IN_A;
                    alarm_d = bus.garage_full;
                end else if (!a && b) begin
                    state_d = OUT_B;
                end else if (a && b) begin
                    state_d = WAIT_CLR;
                end
            end
            // A simultaneous flip to !a&b is resolved as passing through a&b.
            IN_A: begin
                if (b)       state_d = IN_AB;
                else if (!a) state_d = IDLE;
            end
            IN_AB: begin
                if (!a && b)       state_d = IN_B;
                else if (a && !b)  state_d = IN_A;
                else if (!a && !b) state_d = WAIT_CLR;
            end
            IN_B: begin
                if (!a && !b) begin
                    state_d = IDLE;
                    enter_d = 1'b1;
                end else if (a && b) begin
                    state_d = IN_AB;
                end
            end
            // Exit side mirrors the entry side, including the jump rule.
            OUT_B: begin
                if (a)       state_d = OUT_BA;
                else if (!b) state_d = IDLE;
            end
            OUT_BA: begin
                if (a && !b)       state_d = OUT_A;
                else if (!a && b)  state_d = OUT_B;
                else if (!a && !b) state_d = WAIT_CLR;
            end
            OUT_A: begin
                if (!a && !b) begin
                    state_d = IDLE;
                    out_d   = 1'b1;
                end else if (a && b) begin
                    state_d = OUT_BA;
                end
            end
            WAIT_CLR: begin
                if (!a && !b) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Timer runs only while a tracking state holds; any move restarts it.
        if (tracking && (state_d == state_q)) begin
            if (tmr_q == TO_LAST) begin
                state_d = WAIT_CLR;
                fault_d = 1'b1;
                tmr_d   = '0;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end
    end

    // Tracker state, timeout counter and registered pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            enter_q <= 1'b0;
            out_q   <= 1'b0;
            alarm_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            enter_q <= enter_d;
            out_q   <= out_d;
            alarm_q <= alarm_d;
            fault_q <= fault_d;
        end
    end

    assign bus.car_enter    = enter_q;
    assign bus.car_out      = out_q;
    assign bus.full_alarm   = alarm_q;
    assign bus.sensor_fault = fault_q;
    assign bus.fsm_state    = state_q;

endmodule

// File: tb/tb_gate_sensor_fsm.sv
// Bench for gate_sensor_fsm: directed table of passages, hand-written corner
// sequences, and a randomized phase scored against a pattern-position model.
module tb_gate_sensor_fsm;

    localparam int D    = 4;
    localparam int TO   = 1000;
    localparam int HOLD = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gate_sensor_fsm_if bus ();

    gate_sensor_fsm #(.DEBOUNCE(D), .TIMEOUT(TO), .TW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;
    int n_enter = 0, n_out = 0, n_alarm = 0, n_fault = 0;
    int cyc = 0;
    logic [3:0] samp;   // {fault, alarm, out, enter} seen after the last edge

    // Scoreboard fed by the reference model: one entry per clock edge.
    logic [3:0] exp_q[$];

    // Reference model: accepted sensor value = nominal value D+2 edges ago.
    logic [1:0] nom = 2'b00;
    logic [1:0] nq[$];
    logic [1:0] mv = 2'b00;
    bit         model_on = 1'b0;
    int         mdir = 0;    // 0 idle, 1 entering, 2 leaving, 3 wait-for-clear
    int         mpos = 0;    // position along the passage pattern
    int         pin [5] = '{0, 2, 3, 1, 0};   // {a,b}: clear, A, AB, B, clear
    int         pout[5] = '{0, 1, 3, 2, 0};   // {a,b}: clear, B, BA, A, clear

    typedef struct {
        string            name;
        logic [3:0][1:0]  steps;   // steps[3] applied first
        int               n;
        bit               full;
        int               e;
        int               o;
        int               a;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0d, want %0d", name, cyc, got, want);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        tests++;
        if (got < lo || got > hi) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0d, want %0d..%0d", name, cyc, got, lo, hi);
        end
    endtask

    function automatic logic [3:0] model_eval(input logic [1:0] v, input logic gf);
        logic [3:0] e;
        int val, nxt, prv, skip;
        e   = 4'b0000;
        val = int'(v);
        case (mdir)
            0: begin
                if (val == 2) begin
                    mdir = 1; mpos = 1; e[2] = gf;
                end else if (val == 1) begin
                    mdir = 2; mpos = 1;
                end else if (val == 3) begin
                    mdir = 3;
                end
            end
            3: if (val == 0) mdir = 0;
            default: begin
                nxt  = (mdir == 1) ? pin[mpos + 1] : pout[mpos + 1];
                prv  = (mdir == 1) ? pin[mpos - 1] : pout[mpos - 1];
                skip = (mdir == 1) ? pin[3] : pout[3];
                if (val == nxt) begin
                    mpos++;
                    if (mpos == 4) begin
                        if (mdir == 1) e[0] = 1'b1;
                        else           e[1] = 1'b1;
                        mdir = 0;
                    end
                end else if (val == prv) begin
                    mpos--;
                    if (mpos == 0) mdir = 0;
                end else if (mpos == 1 && val == skip) begin
                    mpos = 2;
                end else if (mpos == 2 && val == 0) begin
                    mdir = 3;
                end
            end
        endcase
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_ab(input logic [1:0] v);
        bus.sensor_a = v[1];
        bus.sensor_b = v[0];
    endtask

    // One clock: model runs at the edge, outputs are sampled at the falling edge.
    task automatic step();
        logic [3:0] e;
        @(posedge clk);
        cyc++;
        if (model_on) begin
            nq.push_back(nom);
            if (nq.size() > D + 2) mv = nq.pop_front();
            exp_q.push_back(model_eval(mv, bus.garage_full));
        end
        @(negedge clk);
        samp = {bus.sensor_fault, bus.full_alarm, bus.car_out, bus.car_enter};
        n_enter += int'(samp[0]);
        n_out   += int'(samp[1]);
        n_alarm += int'(samp[2]);
        n_fault += int'(samp[3]);
        if (samp[0] || samp[1]) check("enter_out_exclusive", int'(samp[0] & samp[1]), 0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("model_outputs", int'(samp), int'(e));
        end
    endtask

    task automatic add_vec(input string name, input logic [3:0][1:0] steps, input int n,
                           input bit full, input int e, input int o, input int a);
        vec_t r;
        r.name = name; r.steps = steps; r.n = n; r.full = full;
        r.e = e; r.o = o; r.a = a;
        tbl.push_back(r);
    endtask

    task automatic random_phase();
        logic [1:0] cur, v, raw, gmask;
        int len, gstart, glen;
        cur = 2'b00; nom = 2'b00; set_ab(2'b00);
        nq.delete(); mv = 2'b00; mdir = 0; mpos = 0;
        gstart = 0; gmask = 2'b01;
        model_on = 1'b1;
        for (int s = 0; s < 60; s++) begin
            do v = 2'($urandom_range(0, 3)); while (v == cur);
            len  = $urandom_range(D + 3, 32);
            glen = 0;
            if (len >= 2 * D + 8 && $urandom_range(0, 1) == 1) begin
                glen   = $urandom_range(1, D - 1);
                gstart = D + 2;
                gmask  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            end
            bus.garage_full = 1'($urandom_range(0, 1));
            nom = v;
            cur = v;
            for (int c = 0; c < len; c++) begin
                raw = (glen > 0 && c >= gstart && c < gstart + glen) ? (v ^ gmask) : v;
                set_ab(raw);
                step();
            end
        end
        nom = 2'b00;
        set_ab(2'b00);
        bus.garage_full = 1'b0;
        repeat (30) step();
        model_on = 1'b0;
        step();
    endtask

    // ---------------- main sequence ----------------
    int b_e, b_o, b_a, b_f, lat, bad;

    initial begin
        reset = 1'b0;
        bus.sensor_a = 1'b0;
        bus.sensor_b = 1'b0;
        bus.garage_full = 1'b0;
        samp = 4'b0000;

        // Reset state
        repeat (3) step();
        check("reset_outputs", int'(samp), 0);
        check("reset_state_idle", int'(bus.fsm_state), 0);
        reset = 1'b1;
        repeat (10) step();
        check("post_reset_quiet", n_enter + n_out + n_alarm + n_fault, 0);

        // Normal entry with exact latency from B clearing to car_enter
        set_ab(2'b10); repeat (HOLD) step();
        set_ab(2'b11); repeat (HOLD) step();
        set_ab(2'b01); repeat (HOLD) step();
        b_e = n_enter; b_o = n_out;
        set_ab(2'b00);
        lat = -1;
        for (int k = 1; k <= 50 && lat < 0; k++) begin
            step();
            if (samp[0]) lat = k;
        end
        check("entry_latency_edges", lat, D + 3);
        repeat (HOLD) step();
        check("entry_single_pulse", n_enter - b_e, 1);
        check("entry_no_car_out", n_out - b_o, 0);

        // Table-driven passages; every row ends with both beams clear
        add_vec("exit",          {2'b01, 2'b11, 2'b10, 2'b00}, 3, 1'b0, 0, 1, 0);
        add_vec("entry",         {2'b10, 2'b11, 2'b01, 2'b00}, 3, 1'b0, 1, 0, 0);
        add_vec("abort_a",       {2'b10, 2'b00, 2'b00, 2'b00}, 1, 1'b0, 0, 0, 0);
        add_vec("jump_entry",    {2'b10, 2'b01, 2'b00, 2'b00}, 2, 1'b0, 1, 0, 0);
        add_vec("jump_exit",     {2'b01, 2'b10, 2'b00, 2'b00}, 2, 1'b0, 0, 1, 0);
        add_vec("both_at_once",  {2'b11, 2'b00, 2'b00, 2'b00}, 1, 1'b0, 0, 0, 0);
        add_vec("back_out_ab",   {2'b10, 2'b11, 2'b10, 2'b00}, 3, 1'b0, 0, 0, 0);
        add_vec("ab_clear",      {2'b10, 2'b11, 2'b00, 2'b00}, 2, 1'b0, 0, 0, 0);
        add_vec("in_b_hold",     {2'b10, 2'b11, 2'b01, 2'b10}, 4, 1'b0, 1, 0, 0);
        add_vec("full_entry",    {2'b10, 2'b11, 2'b01, 2'b00}, 3, 1'b1, 1, 0, 1);
        add_vec("full_exit",     {2'b01, 2'b11, 2'b10, 2'b00}, 3, 1'b1, 0, 1, 0);
        add_vec("full_abort",    {2'b10, 2'b00, 2'b00, 2'b00}, 1, 1'b1, 0, 0, 1);
        foreach (tbl[i]) begin
            b_e = n_enter; b_o = n_out; b_a = n_alarm; b_f = n_fault;
            bus.garage_full = tbl[i].full;
            for (int k = 0; k < tbl[i].n; k++) begin
                set_ab(tbl[i].steps[3 - k]);
                repeat (HOLD) step();
            end
            set_ab(2'b00);
            repeat (HOLD) step();
            bus.garage_full = 1'b0;
            check({tbl[i].name, "_enter"}, n_enter - b_e, tbl[i].e);
            check({tbl[i].name, "_out"},   n_out - b_o,   tbl[i].o);
            check({tbl[i].name, "_alarm"}, n_alarm - b_a, tbl[i].a);
            check({tbl[i].name, "_fault"}, n_fault - b_f, 0);
        end

        // Short glitch on B while idle never leaves IDLE
        b_e = n_enter; b_o = n_out; bad = 0;
        set_ab(2'b01);
        repeat (3) begin step(); if (bus.fsm_state != 3'd0) bad++; end
        set_ab(2'b00);
        repeat (HOLD) begin step(); if (bus.fsm_state != 3'd0) bad++; end
        check("glitch_stays_idle", bad, 0);
        check("glitch_no_pulse", (n_enter - b_e) + (n_out - b_o), 0);

        // Stuck sensor A: one fault pulse about TIMEOUT cycles after IN_A
        b_e = n_enter; b_o = n_out; b_f = n_fault;
        set_ab(2'b10);
        lat = -1;
        for (int k = 1; k <= 1200 && lat < 0; k++) begin
            step();
            if (samp[3]) lat = k;
        end
        check_range("fault_latency_edges", lat, D + 3 + TO - 2, D + 3 + TO + 2);
        repeat (1100 - lat) step();
        check("fault_single_pulse", n_fault - b_f, 1);
        set_ab(2'b00);
        repeat (HOLD) step();
        check("fault_release_idle", int'(bus.fsm_state), 0);
        check("fault_no_count", (n_enter - b_e) + (n_out - b_o), 0);

        // Reset in the middle of an entry aborts it silently
        b_e = n_enter; b_o = n_out; b_a = n_alarm; b_f = n_fault; bad = 0;
        set_ab(2'b10); repeat (HOLD) step();
        set_ab(2'b11); repeat (HOLD) step();
        reset = 1'b0;
        set_ab(2'b00);
        repeat (5) begin step(); if (samp != 4'b0000) bad++; end
        reset = 1'b1;
        repeat (HOLD) step();
        check("reset_mid_outputs_low", bad, 0);
        check("reset_mid_no_pulse", (n_enter - b_e) + (n_out - b_o) + (n_alarm - b_a) + (n_fault - b_f), 0);
        set_ab(2'b10); repeat (HOLD) step();
        set_ab(2'b11); repeat (HOLD) step();
        set_ab(2'b01); repeat (HOLD) step();
        set_ab(2'b00); repeat (HOLD) step();
        check("entry_after_reset", n_enter - b_e, 1);

        // Randomized passages, glitches and garage_full against the model
        random_phase();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
